processinho_core: RTL and testbench
===================================

# processinho_core

Execution core of the processinho CPU: the control-signal decoder, the datapath, and a 16×8 data RAM in one block. Each cycle it presents a program-counter address to an external synchronous instruction ROM and accepts the returned 4-bit opcode. It executes opcodes against an 8-bit accumulator and an 8-bit general-purpose register. Architectural state is shown on four active-low 7-segment displays.

## Interface
- No parameters.
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- opcode  in  4  instruction from the external ROM; valid during EXEC.
- data_bus_in  in  4  immediate operand, sampled by LDI and SETMAR.
- rom_enable  out  1  ROM read enable; 1 only in FETCH.
- pc_count  out  4  program counter; the ROM address.
- state  out  2  sequencer state: 0 FETCH, 1 EXEC, 2 MEMRD, 3 HALT.
- ir_value  out  4  opcode latched at the last EXEC edge.
- mar_value  out  4  memory address register.
- data_bus_out  out  8  last value written into ACC or R (internal bus).
- HEX0  out  8  7-seg display of ACC[3:0].
- HEX1  out  8  7-seg display of ACC[7:4].
- HEX2  out  8  7-seg display of R[3:0].
- HEX3  out  8  7-seg display of pc_count.

## Operation
- Internal registers: ACC (8-bit ULA result buffer), R (8-bit general-purpose register), MAR (4-bit), PC (4-bit), IR (4-bit).
- Opcodes are decoded in EXEC. All arithmetic is mod 256. "Imm" is zero-extended data_bus_in.
  - 0 NOP: no effect.
  - 1 LDI: R ← imm.
  - 2 ADD: ACC ← ACC + R.
  - 3 SUB: ACC ← ACC − R.
  - 4 AND: ACC ← ACC & R.
  - 5 OR: ACC ← ACC | R.
  - 6 XOR: ACC ← ACC ^ R.
  - 7 NOT: ACC ← ~ACC.
  - 8 SHL: ACC ← ACC << 1, zero fill.
  - 9 SHR: ACC ← ACC >> 1, logical.
  - A MOVA: ACC ← R.
  - B MOVR: R ← ACC.
  - C SETMAR: MAR ← data_bus_in.
  - D STORE: RAM[MAR] ← ACC.
  - E LOAD: R ← RAM[MAR].
  - F HALT: stop.
- data_bus_out updates whenever ACC or R is written, with the written value. It is unchanged on every other cycle.
- Control-signal decoder (cs):
  - Combinational from opcode and state.
  - Generates the ULA operation, grab_ula (ACC write), latch_ula (ACC→bus), gp_read, gp_write, pc_increment and the RAM enable/write-enable.
  - All of these are inactive outside EXEC and MEMRD.
- RAM:
  - 16×8, synchronous write and registered synchronous read.
  - Not cleared by reset; simulation initial contents are 0.
- 7-segment encoding:
  - Bit 7 is the decimal point, always 1 (off). Bits 6:0 are gfedcba, active low.
  - Digits 0–F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
  - Full byte = encoding | 0x80, e.g. 0 → C0, A → 88.

## Timing
- Sequencer transitions:
  - FETCH → EXEC.
  - EXEC → MEMRD if opcode = E; → HALT if opcode = F; otherwise → FETCH.
  - MEMRD → FETCH.
  - HALT → HALT.
- Instruction length: LOAD takes 3 cycles, HALT is terminal, every other instruction takes 2 cycles.
- FETCH: rom_enable = 1. The ROM samples pc_count on this edge, so opcode is valid throughout EXEC.
- EXEC edge:
  - IR ← opcode.
  - The register, MAR or RAM write for the opcode takes effect.
  - PC increments, except for LOAD and HALT.
  - LOAD issues its RAM read on this edge.
- MEMRD edge: R ← RAM read data; PC increments.
- PC wraps 15 → 0.
- HALT: PC frozen, rom_enable = 0, no register writes. Only reset exits.
- Reset, asserted asynchronously at any time including mid-instruction:
  - state = FETCH, so rom_enable = 1.
  - PC, ACC, R, MAR, IR and data_bus_out = 0.
  - HEX0–HEX3 = C0.
  - An in-flight STORE or LOAD is aborted; RAM contents are preserved.
- HEX outputs are combinational from their registers and update in the same cycle the register changes.

## Test plan
- Reset: hold reset = 0 → state 0, pc_count 0, rom_enable 1, data_bus_out 00, HEX0–HEX3 = C0. Release → state 1 after one edge.
- LDI 5, ADD, ADD → ACC = 0A, HEX0 = 88, HEX1 = C0, HEX2 = 92, pc_count = 3 after 6 cycles.
- Underflow from reset: LDI 1, SUB → ACC = FF, HEX0 = HEX1 = 8E, data_bus_out = FF.
- Memory: LDI 9, MOVA, SETMAR 3, STORE, LDI 0, LOAD → mar_value 3; LOAD spends 3 cycles; R = 09 at the MEMRD edge; HEX2 = 90.
- PC wrap: 16 NOPs from reset → pc_count returns to 0 after 32 cycles, HEX3 = C0.
- HALT: opcode F → state 3, rom_enable 0, pc_count frozen for 10 cycles. Pulse reset mid-halt → state 0, pc_count 0, RAM contents intact.

Source files
------------

// File: rtl/processinho_core_if.sv
// Instruction-ROM port of the processinho core: address/enable out, opcode and immediate back.
// The ROM is synchronous; it samples pc_count on the edge where rom_enable is high.
interface processinho_core_if;
   logic       rom_enable;
   logic [3:0] pc_count;
   logic [3:0] opcode;
   logic [3:0] data_bus_in;

   modport master (output rom_enable, output pc_count, input opcode, input data_bus_in);
   modport slave  (input rom_enable, input pc_count, output opcode, output data_bus_in);
endinterface

// File: rtl/processinho_core.sv
// processinho execution core: sequencer, control decoder, ACC/R datapath, 16x8 RAM, 7-seg drivers.
// Two cycles per instruction (FETCH, EXEC), three for LOAD (adds MEMRD); HALT is terminal until reset.
module processinho_core (
   input  logic                      clock,
   input  logic                      reset,
   processinho_core_if.master        rom,
   output logic [1:0]                state,
   output logic [3:0]                ir_value,
   output logic [3:0]                mar_value,
   output logic [7:0]                data_bus_out,
   output logic [7:0]                HEX0,
   output logic [7:0]                HEX1,
   output logic [7:0]                HEX2,
   output logic [7:0]                HEX3
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_MEMRD = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t     st;
   logic [7:0] acc;
   logic [7:0] r_reg;
   logic [7:0] bus_q;
   logic [7:0] ram_q;
   logic [3:0] pc;
   logic [3:0] mar;
   logic [3:0] ir;
   logic [7:0] mem [16];

   logic       grab_ula;
   logic       latch_ula;
   logic       gp_read;
   logic       gp_write;
   logic       mar_write;
   logic       pc_increment;
   logic       ram_en;
   logic       ram_we;
   logic [3:0] ula_op;
   logic [7:0] ula_b;
   logic [7:0] ula_res;
   logic [7:0] gp_wdata;

   always_comb begin
      grab_ula     = 1'b0;
      latch_ula    = 1'b0;
      gp_read      = 1'b0;
      gp_write     = 1'b0;
      mar_write    = 1'b0;
      pc_increment = 1'b0;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      ula_op       = 4'h0;
      gp_wdata     = 8'h00;
      if (st == S_EXEC) begin
         ula_op       = rom.opcode;
         pc_increment = (rom.opcode != 4'hE) && (rom.opcode != 4'hF);
         case (rom.opcode)
            4'h1: begin
               gp_write = 1'b1;
               gp_wdata = {4'h0, rom.data_bus_in};
            end
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA: begin
               gp_read   = 1'b1;
               grab_ula  = 1'b1;
               latch_ula = 1'b1;
            end
            4'h7, 4'h8, 4'h9: begin
               grab_ula  = 1'b1;
               latch_ula = 1'b1;
            end
            4'hB: begin
               gp_write = 1'b1;
               gp_wdata = acc;
            end
            4'hC: mar_write = 1'b1;
            4'hD: begin
               ram_en = 1'b1;
               ram_we = 1'b1;
            end
            4'hE: ram_en = 1'b1;
            default: ;
         endcase
      end else if (st == S_MEMRD) begin
         gp_write     = 1'b1;
         gp_wdata     = ram_q;
         pc_increment = 1'b1;
      end
   end

   // The second ULA operand is R only when the decoder routes it onto the ULA input.
   assign ula_b = gp_read ? r_reg : 8'h00;

   always_comb begin
      case (ula_op)
         4'h2:    ula_res = acc + ula_b;
         4'h3:    ula_res = acc - ula_b;
         4'h4:    ula_res = acc & ula_b;
         4'h5:    ula_res = acc | ula_b;
         4'h6:    ula_res = acc ^ ula_b;
         4'h7:    ula_res = ~acc;
         4'h8:    ula_res = {acc[6:0], 1'b0};
         4'h9:    ula_res = {1'b0, acc[7:1]};
         4'hA:    ula_res = ula_b;
         default: ula_res = acc;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st    <= S_FETCH;
         pc    <= 4'h0;
         acc   <= 8'h00;
         r_reg <= 8'h00;
         mar   <= 4'h0;
         ir    <= 4'h0;
         bus_q <= 8'h00;
      end else begin
         if (grab_ula)     acc   <= ula_res;
         if (gp_write)     r_reg <= gp_wdata;
         if (mar_write)    mar   <= rom.data_bus_in;
         if (pc_increment) pc    <= pc + 4'd1;
         if (latch_ula)     bus_q <= ula_res;
         else if (gp_write) bus_q <= gp_wdata;
         case (st)
            S_FETCH: st <= S_EXEC;
            S_EXEC: begin
               ir <= rom.opcode;
               if (rom.opcode == 4'hE)      st <= S_MEMRD;
               else if (rom.opcode == 4'hF) st <= S_HALT;
               else                         st <= S_FETCH;
            end
            S_MEMRD: st <= S_FETCH;
            default: st <= S_HALT;
         endcase
      end
   end

   // RAM contents survive reset; reset only stops new enables by forcing FETCH.
   always_ff @(posedge clock) begin
      if (ram_en && ram_we)  mem[mar] <= acc;
      if (ram_en && !ram_we) ram_q    <= mem[mar];
   end

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      return {1'b1, s};
   endfunction

   assign rom.rom_enable = (st == S_FETCH);
   assign rom.pc_count   = pc;
   assign state          = st;
   assign ir_value       = ir;
   assign mar_value      = mar;
   assign data_bus_out   = bus_q;
   assign HEX0           = seg7(acc[3:0]);
   assign HEX1           = seg7(acc[7:4]);
   assign HEX2           = seg7(r_reg[3:0]);
   assign HEX3           = seg7(pc);

endmodule

// File: tb/tb_processinho_core.sv
// Directed bench for processinho_core with a synchronous ROM model driven from program arrays.
module tb_processinho_core;

   logic       clock;
   logic       reset;
   logic [1:0] state;
   logic [3:0] ir_value;
   logic [3:0] mar_value;
   logic [7:0] data_bus_out;
   logic [7:0] HEX0, HEX1, HEX2, HEX3;

   processinho_core_if rif ();

   processinho_core dut (
      .clock        (clock),
      .reset        (reset),
      .rom          (rif.master),
      .state        (state),
      .ir_value     (ir_value),
      .mar_value    (mar_value),
      .data_bus_out (data_bus_out),
      .HEX0         (HEX0),
      .HEX1         (HEX1),
      .HEX2         (HEX2),
      .HEX3         (HEX3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [3:0] rom_op  [16];
   logic [3:0] rom_imm [16];

   always @(posedge clock) begin
      if (rif.rom_enable) begin
         rif.opcode      <= rom_op[rif.pc_count];
         rif.data_bus_in <= rom_imm[rif.pc_count];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h, expected %02h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] t [16];
      t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      return t[d];
   endfunction

   task automatic clear_prog(input logic [3:0] fill);
      for (int i = 0; i < 16; i++) begin
         rom_op[i]  = fill;
         rom_imm[i] = 4'h0;
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   typedef struct {
      logic [3:0] op;
      logic [3:0] imm;
      logic [7:0] acc;
      logic [7:0] r;
      logic [7:0] bus;
   } vec_t;

   vec_t vt [16];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{4'h1, 4'h5, 8'h00, 8'h05, 8'h05};
      vt[1]  = '{4'h2, 4'h0, 8'h05, 8'h05, 8'h05};
      vt[2]  = '{4'h2, 4'h0, 8'h0A, 8'h05, 8'h0A};
      vt[3]  = '{4'h1, 4'h3, 8'h0A, 8'h03, 8'h03};
      vt[4]  = '{4'h3, 4'h0, 8'h07, 8'h03, 8'h07};
      vt[5]  = '{4'h4, 4'h0, 8'h03, 8'h03, 8'h03};
      vt[6]  = '{4'h1, 4'hC, 8'h03, 8'h0C, 8'h0C};
      vt[7]  = '{4'h5, 4'h0, 8'h0F, 8'h0C, 8'h0F};
      vt[8]  = '{4'h6, 4'h0, 8'h03, 8'h0C, 8'h03};
      vt[9]  = '{4'h7, 4'h0, 8'hFC, 8'h0C, 8'hFC};
      vt[10] = '{4'h8, 4'h0, 8'hF8, 8'h0C, 8'hF8};
      vt[11] = '{4'h9, 4'h0, 8'h7C, 8'h0C, 8'h7C};
      vt[12] = '{4'hB, 4'h0, 8'h7C, 8'h7C, 8'h7C};
      vt[13] = '{4'h1, 4'h1, 8'h7C, 8'h01, 8'h01};
      vt[14] = '{4'hA, 4'h0, 8'h01, 8'h01, 8'h01};
      vt[15] = '{4'h0, 4'h0, 8'h01, 8'h01, 8'h01};
      for (int i = 0; i < 16; i++) begin
         rom_op[i]  = vt[i].op;
         rom_imm[i] = vt[i].imm;
      end

      // Reset held: everything cleared.
      reset = 1'b0;
      cycles(2);
      chk("rst_state", {6'd0, state}, 8'h00);
      chk("rst_pc", {4'h0, rif.pc_count}, 8'h00);
      chk("rst_rom_en", {7'd0, rif.rom_enable}, 8'h01);
      chk("rst_bus", data_bus_out, 8'h00);
      chk("rst_hex0", HEX0, 8'hC0);
      chk("rst_hex1", HEX1, 8'hC0);
      chk("rst_hex2", HEX2, 8'hC0);
      chk("rst_hex3", HEX3, 8'hC0);
      reset = 1'b1;
      cycles(1);
      chk("rel_state_exec", {6'd0, state}, 8'h01);
      chk("rel_rom_en", {7'd0, rif.rom_enable}, 8'h00);

      // Instruction table, one check group per completed instruction.
      for (int i = 0; i < 16; i++) begin
         cycles(i == 0 ? 1 : 2);
         chk($sformatf("v%0d_hex0", i), HEX0, seg7(vt[i].acc[3:0]));
         chk($sformatf("v%0d_hex1", i), HEX1, seg7(vt[i].acc[7:4]));
         chk($sformatf("v%0d_hex2", i), HEX2, seg7(vt[i].r[3:0]));
         chk($sformatf("v%0d_bus", i), data_bus_out, vt[i].bus);
         chk($sformatf("v%0d_pc", i), {4'h0, rif.pc_count}, 8'((i + 1) % 16));
         chk($sformatf("v%0d_hex3", i), HEX3, seg7(4'((i + 1) % 16)));
         chk($sformatf("v%0d_ir", i), {4'h0, ir_value}, {4'h0, vt[i].op});
         chk($sformatf("v%0d_state", i), {6'd0, state}, 8'h00);
      end

      // Underflow from reset.
      clear_prog(4'hF);
      rom_op[0] = 4'h1; rom_imm[0] = 4'h1;
      rom_op[1] = 4'h3;
      reset = 1'b0;
      cycles(1);
      reset = 1'b1;
      cycles(4);
      chk("uf_hex0", HEX0, 8'h8E);
      chk("uf_hex1", HEX1, 8'h8E);
      chk("uf_bus", data_bus_out, 8'hFF);

      // Store then load back, then halt.
      clear_prog(4'hF);
      rom_op[0] = 4'h1; rom_imm[0] = 4'h9;
      rom_op[1] = 4'hA;
      rom_op[2] = 4'hC; rom_imm[2] = 4'h3;
      rom_op[3] = 4'hD;
      rom_op[4] = 4'h1; rom_imm[4] = 4'h0;
      rom_op[5] = 4'hE;
      rom_op[6] = 4'hF;
      reset = 1'b0;
      cycles(1);
      reset = 1'b1;
      cycles(6);
      chk("mem_mar", {4'h0, mar_value}, 8'h03);
      cycles(4);
      chk("mem_ldi0_hex2", HEX2, 8'hC0);
      cycles(2);
      chk("mem_load_memrd", {6'd0, state}, 8'h02);
      chk("mem_load_pc_hold", {4'h0, rif.pc_count}, 8'h05);
      chk("mem_load_r_pending", HEX2, 8'hC0);
      cycles(1);
      chk("mem_load_done_state", {6'd0, state}, 8'h00);
      chk("mem_load_hex2", HEX2, 8'h90);
      chk("mem_load_bus", data_bus_out, 8'h09);
      chk("mem_load_pc", {4'h0, rif.pc_count}, 8'h06);
      cycles(2);
      chk("halt_state", {6'd0, state}, 8'h03);
      chk("halt_rom_en", {7'd0, rif.rom_enable}, 8'h00);
      cycles(10);
      chk("halt_state_10", {6'd0, state}, 8'h03);
      chk("halt_pc_frozen", {4'h0, rif.pc_count}, 8'h06);
      chk("halt_bus_frozen", data_bus_out, 8'h09);

      // Reset mid-halt, then a LOAD aborted by reset, then the LOAD again.
      clear_prog(4'hF);
      rom_op[0] = 4'hC; rom_imm[0] = 4'h3;
      rom_op[1] = 4'hE;
      reset = 1'b0;
      #1;
      chk("hrst_state", {6'd0, state}, 8'h00);
      chk("hrst_pc", {4'h0, rif.pc_count}, 8'h00);
      chk("hrst_rom_en", {7'd0, rif.rom_enable}, 8'h01);
      cycles(1);
      reset = 1'b1;
      cycles(4);
      chk("abort_pre_state", {6'd0, state}, 8'h02);
      reset = 1'b0;
      #1;
      chk("abort_state", {6'd0, state}, 8'h00);
      chk("abort_mar", {4'h0, mar_value}, 8'h00);
      cycles(1);
      reset = 1'b1;
      cycles(1);
      chk("abort_r_clear", HEX2, 8'hC0);
      cycles(4);
      chk("reload_hex2", HEX2, 8'h90);
      chk("reload_pc", {4'h0, rif.pc_count}, 8'h02);
      cycles(2);
      chk("reload_halt", {6'd0, state}, 8'h03);

      // PC wrap over 16 NOPs.
      clear_prog(4'h0);
      reset = 1'b0;
      cycles(1);
      reset = 1'b1;
      cycles(30);
      chk("wrap_pc15", {4'h0, rif.pc_count}, 8'h0F);
      chk("wrap_hex3_15", HEX3, 8'h8E);
      cycles(2);
      chk("wrap_pc0", {4'h0, rif.pc_count}, 8'h00);
      chk("wrap_hex3_0", HEX3, 8'hC0);
      chk("wrap_state", {6'd0, state}, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
